// File: rtl/traffic_light_ctrl_if.sv
// Lamp-controller bus: tick/demand/emergency inputs toward the controller,
// lamp pattern and phase status back to the lamp driver.
interface traffic_light_ctrl_if #(
  parameter int N_DIR = 4,
  parameter int DIR_W = 3
);
  logic                 tick;
  logic [N_DIR-1:0]     demand;
  logic                 emerg_req;
  logic [DIR_W-1:0]     emerg_dir;
  logic [3*N_DIR-1:0]   lights;
  logic [DIR_W-1:0]     active_dir;
  logic [1:0]           phase;

  modport master (
    output tick, demand, emerg_req, emerg_dir,
    input  lights, active_dir, phase
  );

  modport slave (
    input  tick, demand, emerg_req, emerg_dir,
    output lights, active_dir, phase
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// N-direction demand-driven traffic light controller, tick-timed phases.
// Optional emergency preemption is compiled in with `define EMERG_EN.
module traffic_light_ctrl #(
  parameter int N_DIR    = 4,
  parameter int DIR_W    = 3,
  parameter int GREEN_T  = 6,
  parameter int YELLOW_T = 1,
  parameter int ALLRED_T = 1,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    ALL_RED = 2'b10,
    EMERG   = 2'b11
  } phase_t;

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(ALLRED_T - 1);

  phase_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DIR_W-1:0]   dir;
  logic               other_dem;
  logic               em_go;
  logic [DIR_W-1:0]   em_tgt;

  // Round-robin search starting after cur; falls back to cur+1 when idle.
  function automatic logic [DIR_W-1:0] next_dir(input logic [DIR_W-1:0] cur,
                                                input logic [N_DIR-1:0] dem);
    logic [DIR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = DIR_W'((int'(cur) + 1) % N_DIR);
    found = 1'b0;
    for (int k = 1; k <= N_DIR; k++) begin
      idx = (int'(cur) + k) % N_DIR;
      if (!found && dem[idx]) begin
        pick  = DIR_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign other_dem = |(bus.demand & ~(N_DIR'(1) << dir));

`ifdef EMERG_EN
  logic             em_pend;
  logic [DIR_W-1:0] em_dir;
  logic             em_acc;

  // A new request is only latched while none is outstanding, so emerg_dir
  // is frozen from acceptance until the emergency phase is released.
  assign em_acc = !em_pend && bus.emerg_req && (int'(bus.emerg_dir) < N_DIR);
  assign em_go  = em_pend || em_acc;
  assign em_tgt = em_pend ? em_dir : bus.emerg_dir;
`else
  assign em_go  = 1'b0;
  assign em_tgt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GREEN;
      cnt   <= '0;
      dir   <= '0;
`ifdef EMERG_EN
      em_pend <= 1'b0;
      em_dir  <= '0;
`endif
    end else begin
`ifdef EMERG_EN
      if (em_acc) begin
        em_pend <= 1'b1;
        em_dir  <= bus.emerg_dir;
      end
`endif
      case (state)
        GREEN: begin
          if (em_go && em_tgt == dir) begin
            state <= EMERG;
          end else if (em_go) begin
            state <= YELLOW;
            cnt   <= '0;
          end else if (bus.tick) begin
            if (cnt == G_LAST) begin
              // Green extension: hold at expiry until someone else waits.
              if (other_dem) begin
                state <= YELLOW;
                cnt   <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        YELLOW: begin
          if (bus.tick) begin
            if (cnt == Y_LAST) begin
              state <= ALL_RED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ALL_RED: begin
          if (bus.tick) begin
            if (cnt == R_LAST) begin
              cnt <= '0;
              if (em_go) begin
                dir   <= em_tgt;
                state <= EMERG;
              end else begin
                dir   <= next_dir(dir, bus.demand);
                state <= GREEN;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
`ifdef EMERG_EN
          if (!bus.emerg_req) begin
            state   <= YELLOW;
            cnt     <= '0;
            em_pend <= 1'b0;
          end
`else
          state <= GREEN;
          cnt   <= '0;
          dir   <= '0;
`endif
        end
      endcase
    end
  end

  always_comb begin
    bus.lights = '0;
    for (int i = 0; i < N_DIR; i++) begin
      bus.lights[3*i +: 3] = 3'b001;
      if (DIR_W'(i) == dir) begin
        case (state)
          GREEN, EMERG: bus.lights[3*i +: 3] = 3'b100;
          YELLOW:       bus.lights[3*i +: 3] = 3'b010;
          default:      bus.lights[3*i +: 3] = 3'b001;
        endcase
      end
    end
  end

  assign bus.active_dir = dir;
  assign bus.phase      = state;

endmodule
